// File: rtl/xbar_cfg_sequencer_pkg.sv
// Shared types, geometry and address encoding for the XBar2 configuration sequencer.
package xbar_cfg_pkg;

  localparam int XBAR_IN_PORTS      = 4;
  localparam int XBAR_OUT_PORTS     = 4;
  localparam int XBAR_SETTLE_CYCLES = 2;

  localparam int XBAR_SEL_W  = $clog2(XBAR_IN_PORTS);
  localparam int XBAR_OIDX_W = $clog2(XBAR_OUT_PORTS);
  localparam int XBAR_ADDR_W = 1 + XBAR_OIDX_W + XBAR_SEL_W;

  // MSB set means "no write": the bus parks here whenever nothing is programmed.
  localparam logic [XBAR_ADDR_W-1:0] XBAR_REST_ADDR = {1'b1, {(XBAR_ADDR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REST   = 2'd2,
    ST_SETTLE = 2'd3
  } seq_state_e;

  // Route write: MSB clear, then output index, then input selector.
  function automatic logic [XBAR_ADDR_W-1:0] xbar_addr_encode(
    input logic [XBAR_OIDX_W-1:0] k,
    input logic [XBAR_SEL_W-1:0]  sel
  );
    return {1'b0, k, sel};
  endfunction

endpackage

// File: rtl/xbar_cfg_sequencer_if.sv
// Configuration handshake between a route-map requester and the sequencer.
interface xbar_cfg_sequencer_if #(
  parameter int OUT_PORTS = 4,
  parameter int SEL_W     = 2
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [OUT_PORTS*SEL_W-1:0] cfg_route;
  logic [OUT_PORTS-1:0]       cfg_mask;
  logic                       cfg_direct;

  modport master (
    output cfg_valid, cfg_route, cfg_mask, cfg_direct,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_route, cfg_mask, cfg_direct,
    output cfg_ready
  );
endinterface

// File: rtl/xbar_cfg_sequencer.sv
// Serialises an accepted route map into per-output AddressSelect writes,
// parks the bus, applies direct mode and waits a settle time before done.
module xbar_cfg_sequencer
  import xbar_cfg_pkg::*;
#(
  parameter int IN_PORTS      = XBAR_IN_PORTS,
  parameter int OUT_PORTS     = XBAR_OUT_PORTS,
  parameter int SETTLE_CYCLES = XBAR_SETTLE_CYCLES
) (
  input  logic                    Clk,
  input  logic                    Rst,
  xbar_cfg_sequencer_if.slave     cfg,
  output logic [XBAR_ADDR_W-1:0]  AddressSelect,
  output logic                    direct,
  output logic                    busy,
  output logic                    done
);

  localparam int SEL_W  = $clog2(IN_PORTS);
  localparam int OIDX_W = $clog2(OUT_PORTS);
  localparam int ADDR_W = 1 + OIDX_W + SEL_W;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] REST_ADDR   = XBAR_REST_ADDR;
  localparam logic [OIDX_W-1:0] LAST_IDX    = OIDX_W'(OUT_PORTS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e                 state_r;
  logic [OIDX_W-1:0]          idx_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [OUT_PORTS*SEL_W-1:0] route_r;
  logic [OUT_PORTS-1:0]       mask_r;
  logic                       direct_lat_r;
  logic [SEL_W-1:0]           shadow_r [OUT_PORTS];
  logic [OUT_PORTS-1:0]       valid_r;
  logic [ADDR_W-1:0]          addr_r;
  logic                       direct_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       ready_r;

  logic                       accept_s;
  logic                       load_entry_s;
  logic [OUT_PORTS*SEL_W-1:0] src_route_s;
  logic [OUT_PORTS-1:0]       src_mask_s;
  logic [OIDX_W-1:0]          scan_idx_s;
  logic [SEL_W-1:0]           scan_sel_s;
  logic                       write_s;

  // Decide what the next LOAD cycle emits; on acceptance the incoming map is
  // used directly so output 0 can be written on the first cycle after the handshake.
  always_comb begin
    accept_s     = ready_r & cfg.cfg_valid;
    load_entry_s = accept_s | ((state_r == ST_LOAD) & (idx_r != LAST_IDX));
    src_route_s  = accept_s ? cfg.cfg_route : route_r;
    src_mask_s   = accept_s ? cfg.cfg_mask  : mask_r;
    scan_idx_s   = accept_s ? {OIDX_W{1'b0}} : (idx_r + OIDX_W'(1));
    scan_sel_s   = src_route_s[scan_idx_s*SEL_W +: SEL_W];
    write_s      = load_entry_s & src_mask_s[scan_idx_s] &
                   (~valid_r[scan_idx_s] | (shadow_r[scan_idx_s] != scan_sel_s));
  end

  // Sequencer FSM with registered bus, handshake and status outputs plus shadow table.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {OIDX_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      route_r      <= {(OUT_PORTS*SEL_W){1'b0}};
      mask_r       <= {OUT_PORTS{1'b0}};
      direct_lat_r <= 1'b0;
      valid_r      <= {OUT_PORTS{1'b0}};
      addr_r       <= REST_ADDR;
      direct_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ready_r      <= 1'b0;
      for (int i = 0; i < OUT_PORTS; i++) begin
        shadow_r[i] <= {SEL_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      addr_r <= write_s ? ADDR_W'(xbar_addr_encode(scan_idx_s, scan_sel_s)) : REST_ADDR;
      if (write_s) begin
        shadow_r[scan_idx_s] <= scan_sel_s;
        valid_r[scan_idx_s]  <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (accept_s) begin
        state_r      <= ST_LOAD;
        idx_r        <= {OIDX_W{1'b0}};
        route_r      <= cfg.cfg_route;
        mask_r       <= cfg.cfg_mask;
        direct_lat_r <= cfg.cfg_direct;
        ready_r      <= 1'b0;
        busy_r       <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
          ST_LOAD: begin
            if (idx_r == LAST_IDX) begin
              state_r  <= ST_REST;
              direct_r <= direct_lat_r;
            end else begin
              idx_r <= scan_idx_s;
            end
          end
          ST_REST: begin
            state_r <= ST_SETTLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= (SETTLE_CYCLES == 1);
            ready_r <= (SETTLE_CYCLES == 1);
          end
          ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
              done_r  <= ((cnt_r + CNT_W'(1)) == SETTLE_LAST);
              ready_r <= ((cnt_r + CNT_W'(1)) == SETTLE_LAST);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg.cfg_ready = ready_r;
  assign AddressSelect = addr_r;
  assign direct        = direct_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_xbar_cfg_sequencer.sv
// Directed self-checking bench for xbar_cfg_sequencer (4x4, settle 2).
module tb_xbar_cfg_sequencer;

  logic       Clk;
  logic       Rst;
  logic [4:0] AddressSelect;
  logic       direct;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] nxt_route;
  logic [3:0] nxt_mask;
  logic       nxt_direct;

  xbar_cfg_sequencer_if #(.OUT_PORTS(4), .SEL_W(2)) cfg_bus ();

  xbar_cfg_sequencer #(.IN_PORTS(4), .OUT_PORTS(4), .SETTLE_CYCLES(2)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .cfg           (cfg_bus.slave),
    .AddressSelect (AddressSelect),
    .direct        (direct),
    .busy          (busy),
    .done          (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a configuration at a negedge; the following posedge is acceptance edge N.
  task automatic offer(input string nm, input logic [7:0] r, input logic [3:0] m, input logic d);
    @(negedge Clk);
    cfg_bus.cfg_route  = r;
    cfg_bus.cfg_mask   = m;
    cfg_bus.cfg_direct = d;
    cfg_bus.cfg_valid  = 1'b1;
    check_eq({nm, "_ready_pre"}, 32'(cfg_bus.cfg_ready), 32'd1);
    @(posedge Clk);
  endtask

  // Check cycles N+1..N+7; ea packs {k3,k2,k1,k0} expected LOAD addresses.
  task automatic expect_seq(input string nm, input logic [19:0] ea, input logic d_old,
                            input logic d_new, input int inject_at);
    logic [4:0] e;
    for (int i = 1; i <= 7; i++) begin
      @(negedge Clk);
      e = (i <= 4) ? ea[(i-1)*5 +: 5] : 5'h10;
      check_eq($sformatf("%s_addr_c%0d", nm, i), 32'(AddressSelect), 32'(e));
      check_eq($sformatf("%s_busy_c%0d", nm, i), 32'(busy), 32'd1);
      check_eq($sformatf("%s_done_c%0d", nm, i), 32'(done), 32'(i == 7));
      check_eq($sformatf("%s_ready_c%0d", nm, i), 32'(cfg_bus.cfg_ready), 32'(i == 7));
      check_eq($sformatf("%s_direct_c%0d", nm, i), 32'(direct), 32'((i >= 5) ? d_new : d_old));
      if (i == 1) cfg_bus.cfg_valid = 1'b0;
      if (i == inject_at) begin
        cfg_bus.cfg_route  = nxt_route;
        cfg_bus.cfg_mask   = nxt_mask;
        cfg_bus.cfg_direct = nxt_direct;
        cfg_bus.cfg_valid  = 1'b1;
      end
    end
  endtask

  initial begin
    Rst                = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_route  = 8'h00;
    cfg_bus.cfg_mask   = 4'h0;
    cfg_bus.cfg_direct = 1'b0;
    nxt_route          = 8'h00;
    nxt_mask           = 4'h0;
    nxt_direct         = 1'b0;

    // Reset for two cycles, then release.
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check_eq("rst_addr", 32'(AddressSelect), 32'h10);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_eq("rel_addr", 32'(AddressSelect), 32'h10);
    check_eq("rel_direct", 32'(direct), 32'd0);
    check_eq("rel_busy", 32'(busy), 32'd0);
    check_eq("rel_done", 32'(done), 32'd0);
    check_eq("rel_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // out0<-in3, out1<-in2, out2<-in1, out3<-in0: writes 3,6,9,12.
    offer("p1", 8'h1B, 4'hF, 1'b0);
    expect_seq("p1", {5'd12, 5'd9, 5'd6, 5'd3}, 1'b0, 1'b0, 0);

    // Same map again with direct=1: nothing rewritten, direct rises at N+5.
    offer("p2", 8'h1B, 4'hF, 1'b1);
    expect_seq("p2", {5'h10, 5'h10, 5'h10, 5'h10}, 1'b0, 1'b1, 0);

    // Only out2 changes to in3: single write of 11 at N+3.
    offer("p3", 8'h3B, 4'hF, 1'b1);
    expect_seq("p3", {5'h10, 5'd11, 5'h10, 5'h10}, 1'b1, 1'b1, 0);

    // out0<-in0 (write 0); a second offer is raised during LOAD and held.
    nxt_route  = 8'h1B;
    nxt_mask   = 4'h1;
    nxt_direct = 1'b1;
    offer("pa", 8'h38, 4'hF, 1'b0);
    expect_seq("pa", {5'h10, 5'h10, 5'h10, 5'd0}, 1'b1, 1'b0, 2);
    // Held offer is taken in the done cycle; its LOAD begins straight after.
    @(posedge Clk);
    expect_seq("pb", {5'h10, 5'h10, 5'h10, 5'd3}, 1'b0, 1'b1, 0);

    // All outputs change; reset lands at N+2.
    offer("pc", 8'hE4, 4'hF, 1'b0);
    @(negedge Clk);
    cfg_bus.cfg_valid = 1'b0;
    check_eq("pc_addr_c1", 32'(AddressSelect), 32'd0);
    @(negedge Clk);
    check_eq("pc_addr_c2", 32'(AddressSelect), 32'd5);
    check_eq("pc_direct_c2", 32'(direct), 32'd1);
    Rst = 1'b0;
    @(negedge Clk);
    check_eq("pc_rst_addr", 32'(AddressSelect), 32'h10);
    check_eq("pc_rst_busy", 32'(busy), 32'd0);
    check_eq("pc_rst_direct", 32'(direct), 32'd0);
    check_eq("pc_rst_done", 32'(done), 32'd0);
    check_eq("pc_rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    check_eq("pc_rel_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_eq("pc_rel_addr", 32'(AddressSelect), 32'h10);

    // Same map after reset: valid bits cleared, so every output is rewritten.
    offer("pd", 8'hE4, 4'hF, 1'b0);
    expect_seq("pd", {5'd15, 5'd10, 5'd5, 5'd0}, 1'b0, 1'b0, 0);

    // Empty mask: full-length sequence, no writes, direct still applied.
    offer("pe", 8'h1B, 4'h0, 1'b1);
    expect_seq("pe", {5'h10, 5'h10, 5'h10, 5'h10}, 1'b0, 1'b1, 0);

    @(negedge Clk);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_done", 32'(done), 32'd0);
    check_eq("end_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
